// File: rtl/serial_bit_feeder.sv
// Purpose : serialize WIDTH-bit words onto a one-bit stream, MSB or LSB first, with a one-word skid/hold buffer.
// Latency : first bit of an accepted word appears the cycle after acceptance; back-to-back words stream with no gap.
// Backpressure: din_ready drops while the holding register is occupied; a held din_valid simply waits for it to rise.
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             transfer;
    logic             last_bit;
    logic             head_bit;
    logic [WIDTH-1:0] shift_adv;

    // Handshake and status decode; ready depends only on registered state.
    assign din_ready = ~hold_full_q;
    assign transfer  = din_valid & ~hold_full_q;
    assign last_bit  = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
    assign head_bit  = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign shift_adv = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

    assign ser_valid = (state_q == ST_SHIFT);
    assign ser_out   = ser_valid & head_bit;
    assign word_done = last_bit;

    // Next-state logic: load, shift, park in the holding register, or chain the next word on the last bit.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    shift_d = din;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        // Parked word goes first so acceptance order is preserved.
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (transfer) begin
                        shift_d = din;
                    end else begin
                        shift_d = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    shift_d = shift_adv;
                    cnt_d   = cnt_q + 1'b1;
                    // Ready implies the holding register is empty here.
                    if (transfer) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                hold_full_d = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous clear of everything, including in-flight words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Purpose : random and directed bench for serial_bit_feeder, MSB-first and LSB-first instances side by side.
// Latency : reference model tracks bits-remaining per word; outputs compared every cycle on the falling edge.
// Backpressure: model holds at most one parked word; din_ready is expected low exactly while it is occupied.
module tb_serial_bit_feeder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;

    logic din_ready_m, ser_out_m, ser_valid_m, word_done_m;
    logic din_ready_l, ser_out_l, ser_valid_l, word_done_l;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_m),
        .ser_out(ser_out_m), .ser_valid(ser_valid_m), .word_done(word_done_m)
    );

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_l),
        .ser_out(ser_out_l), .ser_valid(ser_valid_l), .word_done(word_done_l)
    );

    always #5 clk = ~clk;

    // Reference model: word being emitted, bits left in it, and one optional parked word.
    logic [W-1:0] m_word  = '0;
    logic [W-1:0] m_hword = '0;
    int           m_left  = 0;
    bit           m_held  = 1'b0;
    logic [W-1:0] acc_q[$];
    wire          m_xfer = din_valid && !m_held;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_held <= 1'b0;
            acc_q.delete();
        end else begin
            if (m_xfer) acc_q.push_back(din);
            if (m_left == 0) begin
                if (m_xfer) begin
                    m_word <= din;
                    m_left <= W;
                end
            end else if (m_left == 1) begin
                if (m_held) begin
                    m_word <= m_hword;
                    m_held <= 1'b0;
                    m_left <= W;
                end else if (m_xfer) begin
                    m_word <= din;
                    m_left <= W;
                end else begin
                    m_left <= 0;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_xfer) begin
                    m_hword <= din;
                    m_held  <= 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    logic [7:0] mon_exp, mon_got;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            mon_exp = 8'b0001_0001;
            if (m_left > 0) begin
                mon_exp[7] = 1'b1;
                mon_exp[6] = m_word[m_left-1];
                mon_exp[5] = (m_left == 1);
                mon_exp[3] = 1'b1;
                mon_exp[2] = m_word[W-m_left];
                mon_exp[1] = (m_left == 1);
            end
            mon_exp[4] = !m_held;
            mon_exp[0] = !m_held;
            mon_got = {ser_valid_m, ser_out_m, word_done_m, din_ready_m,
                       ser_valid_l, ser_out_l, word_done_l, din_ready_l};
            n_cmp++;
            if (mon_got !== mon_exp) begin
                n_err++;
                $display("FAIL monitor t=%0t: got v/o/wd/rdy(m,l)=%b required %b", $time, mon_got, mon_exp);
            end
        end
    end

    // Word-level order check: reassemble MSB-first words and match against acceptance order.
    logic [W-1:0] col_asm = '0;
    logic [W-1:0] col_next;
    assign col_next = {col_asm[W-2:0], ser_out_m};
    always @(negedge clk) begin
        if (rst) begin
            col_asm <= '0;
        end else if (mon_en && ser_valid_m) begin
            col_asm <= col_next;
            if (word_done_m) begin
                n_cmp++;
                if (acc_q.size() == 0) begin
                    n_err++;
                    $display("FAIL stream_order: got word %h required none pending", col_next);
                end else begin
                    if (col_next !== acc_q[0]) begin
                        n_err++;
                        $display("FAIL stream_order: got word %h required %h", col_next, acc_q[0]);
                    end
                    void'(acc_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ser_valid_m, ser_out_m, word_done_m, din_ready_m, ser_valid_l, ser_out_l, word_done_l, din_ready_l} !== 8'b0001_0001) begin
            n_err++;
            $display("FAIL reset_async: got %b required 00010001",
                     {ser_valid_m, ser_out_m, word_done_m, din_ready_m, ser_valid_l, ser_out_l, word_done_l, din_ready_l});
        end
        din_valid = 1'b1;
        din = 8'hFF;
        tick();
        n_cmp++;
        if ({ser_valid_m, ser_out_m, word_done_m, din_ready_m} !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_held: got %b required 0001", {ser_valid_m, ser_out_m, word_done_m, din_ready_m});
        end
        din_valid = 1'b0;
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({ser_valid_m, din_ready_m, ser_valid_l, din_ready_l} !== 4'b0101) begin
            n_err++;
            $display("FAIL reset_release: got %b required 0101", {ser_valid_m, din_ready_m, ser_valid_l, din_ready_l});
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single_word(input logic [W-1:0] w, input string name);
        logic [5:0] got, exp;
        din = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        din = ~w;
        for (int i = 0; i < W; i++) begin
            got = {ser_valid_m, ser_out_m, word_done_m, ser_valid_l, ser_out_l, word_done_l};
            exp = {1'b1, w[W-1-i], (i == W-1), 1'b1, w[i], (i == W-1)};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s bit%0d: got %b required %b", name, i, got, exp);
            end
            tick();
        end
        n_cmp++;
        if ({ser_valid_m, ser_out_m, word_done_m, ser_valid_l} !== 4'b0000) begin
            n_err++;
            $display("FAIL %s after: got %b required 0000", name, {ser_valid_m, ser_out_m, word_done_m, ser_valid_l});
        end
    endtask

    // Two words, the second offered at cycle offer_k after the first was accepted.
    task automatic test_two_words(input int offer_k, input string name);
        logic [W-1:0] a, b;
        logic [3:0]   got, exp;
        a = W'($urandom);
        b = W'($urandom);
        din = a;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int k = 1; k <= 2*W + 1; k++) begin
            if (k == offer_k) begin
                din = b;
                din_valid = 1'b1;
            end
            if (k == offer_k + 1) din_valid = 1'b0;
            exp = 4'b0001;
            if (k <= W) exp[2] = a[W-k];
            else if (k <= 2*W) exp[2] = b[2*W-k];
            exp[3] = (k <= 2*W);
            exp[1] = (k == W) || (k == 2*W);
            exp[0] = !(offer_k < W && k > offer_k && k <= W);
            got = {ser_valid_m, ser_out_m, word_done_m, din_ready_m};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s k=%0d: got v/o/wd/rdy=%b required %b", name, k, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_three_words();
        logic [W-1:0]   ws[3];
        logic [3*W-1:0] bits;
        int idx, nvalid, first, last;
        bit waited, acc;
        for (int i = 0; i < 3; i++) ws[i] = W'($urandom);
        bits = '0; idx = 0; nvalid = 0; first = -1; last = -1; waited = 1'b0;
        din = ws[0];
        din_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (ser_valid_m) begin
                bits = {bits[3*W-2:0], ser_out_m};
                nvalid++;
                if (first < 0) first = c;
                last = c;
            end
            if (din_valid && !din_ready_m) waited = 1'b1;
            acc = din_valid && din_ready_m;
            tick();
            if (acc) begin
                idx++;
                if (idx < 3) din = ws[idx];
                else din_valid = 1'b0;
            end
        end
        din_valid = 1'b0;
        n_cmp++;
        if (idx != 3) begin n_err++; $display("FAIL three_accept: got %0d words required 3", idx); end
        n_cmp++;
        if (nvalid != 3*W || (last - first + 1) != 3*W) begin
            n_err++;
            $display("FAIL three_contig: got %0d valid over span %0d required %0d", nvalid, last - first + 1, 3*W);
        end
        n_cmp++;
        if (bits !== {ws[0], ws[1], ws[2]}) begin
            n_err++;
            $display("FAIL three_data: got %h required %h", bits, {ws[0], ws[1], ws[2]});
        end
        n_cmp++;
        if (!waited) begin n_err++; $display("FAIL three_wait: got no stall required third word to wait"); end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] c;
        din = W'($urandom);
        din_valid = 1'b1;
        tick();
        din = W'($urandom);
        tick();
        din_valid = 1'b0;
        tick();
        n_cmp++;
        if ({ser_valid_m, din_ready_m} !== 2'b10) begin
            n_err++;
            $display("FAIL midrst_pre: got v/rdy=%b required 10", {ser_valid_m, din_ready_m});
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({ser_valid_m, ser_out_m, word_done_m, din_ready_m, ser_valid_l, ser_out_l, word_done_l, din_ready_l} !== 8'b0001_0001) begin
            n_err++;
            $display("FAIL midrst_async: got %b required 00010001",
                     {ser_valid_m, ser_out_m, word_done_m, din_ready_m, ser_valid_l, ser_out_l, word_done_l, din_ready_l});
        end
        #1 rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({ser_valid_m, din_ready_m} !== 2'b01) begin
            n_err++;
            $display("FAIL midrst_idle: got v/rdy=%b required 01", {ser_valid_m, din_ready_m});
        end
        c = W'($urandom);
        din = c;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        n_cmp++;
        if ({ser_valid_m, ser_out_m} !== {1'b1, c[W-1]}) begin
            n_err++;
            $display("FAIL midrst_restart: got v/o=%b required %b", {ser_valid_m, ser_out_m}, {1'b1, c[W-1]});
        end
        repeat (W + 1) tick();
    endtask

    task automatic test_random();
        int p;
        for (int c = 0; c < 3000; c++) begin
            p = (c < 1000) ? 30 : (c < 2000) ? 75 : 100;
            din = W'($urandom);
            din_valid = ($urandom_range(0, 99) < p);
            if (c == 1500 || c == 2600) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            tick();
        end
        din_valid = 1'b0;
        repeat (3*W) tick();
        n_cmp++;
        if (acc_q.size() != 0) begin
            n_err++;
            $display("FAIL random_drain: got %0d words undelivered required 0", acc_q.size());
        end
    endtask

    initial begin
        rst = 1'b0;
        din = '0;
        din_valid = 1'b0;
        #1;
        test_reset();
        test_single_word(8'b0110_1010, "msb_pattern");
        test_single_word(8'h0B, "lsb_pattern");
        test_two_words(3, "hold_word");
        test_two_words(W, "last_cycle_offer");
        test_three_words();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_bit_feeder.md
SERIAL_BIT_FEEDER -- requirements
Module: serial_bit_feeder

Interface
REQ-001 Parameter WIDTH, default 8: bits per parallel word; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift MSB first, 0 = shift LSB first.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port din  input  WIDTH  parallel word to serialize.
REQ-006 Port din_valid  input  1  din holds a word offered for transfer.
REQ-007 Port din_ready  output  1  feeder can accept a word this cycle.
REQ-008 Port ser_out  output  1  serial bit stream; drives the sequence detector's serial input.
REQ-009 Port ser_valid  output  1  ser_out carries a live bit this cycle.
REQ-010 Port word_done  output  1  one-cycle pulse marking the last bit of a word.

Function
REQ-011 Transfer SHALL occur on a rising edge where din_valid=1 and din_ready=1; other din values are ignored.
REQ-012 Storage SHALL be one shift register, one WIDTH-bit holding register with hold_full flag, and a bit counter of ceil(log2(WIDTH)) bits.
REQ-013 din_ready SHALL equal NOT hold_full, combinational from registers only; it SHALL NOT depend on din_valid.
REQ-014 FSM states SHALL be IDLE and SHIFT; ser_valid SHALL be 1 exactly when state=SHIFT.
REQ-015 IDLE, transfer at edge N: word SHALL load directly into shift register, counter=0, state=SHIFT; first bit valid in cycle N+1.
REQ-016 SHIFT: each edge SHALL advance one bit and increment counter; bit order per MSB_FIRST.
REQ-017 ser_out SHALL be the current head bit of the shift register while ser_valid=1, and 0 while ser_valid=0.
REQ-018 word_done SHALL be 1 exactly in the cycle counter=WIDTH-1 and state=SHIFT.
REQ-019 Transfer during SHIFT with hold empty, not on last-bit cycle: word SHALL go to holding register, hold_full=1.
REQ-020 Last-bit edge with hold_full=1: holding register SHALL load into shift register, hold_full=0, counter=0, stay SHIFT; no idle cycle between words.
REQ-021 Last-bit edge with hold empty and a transfer on that edge: din SHALL load directly into shift register, stay SHIFT, no gap.
REQ-022 Last-bit edge with hold empty and no transfer: state SHALL go to IDLE; ser_valid=0 next cycle.
REQ-023 A word SHALL never be dropped, duplicated or reordered; words emerge in acceptance order.
REQ-024 din_valid held while din_ready=0 SHALL have no effect; word accepted on first edge with din_ready=1.

Reset
REQ-025 rst=1 SHALL immediately, without a clock edge, force state=IDLE, counter=0, hold_full=0, shift and holding registers=0.
REQ-026 During and after reset: ser_out=0, ser_valid=0, word_done=0, din_ready=1.
REQ-027 Reset mid-word SHALL discard shifting and held words; the first edge after rst deasserts SHALL behave as IDLE.

Verification
REQ-028 Reset during bit 3 of a word -> ser_valid, ser_out, word_done drop to 0 and din_ready=1 within the same cycle, before any clock edge.
REQ-029 MSB_FIRST=1, din=8'b0110_1010 accepted at edge N -> ser_out 0,1,1,0,1,0,1,0 in cycles N+1..N+8; word_done only in N+8; ser_valid=0 in N+9.
REQ-030 MSB_FIRST=0, din=8'h0B -> ser_out 1,1,0,1,0,0,0,0; word_done on 8th bit.
REQ-031 Second word offered in cycle N+3 of first -> accepted into hold, din_ready=0 until N+8 edge, 16 contiguous ser_valid cycles, word_done in N+8 and N+16.
REQ-032 Word offered only in last-bit cycle with hold empty -> accepted, next word's first bit in following cycle, no ser_valid gap.
REQ-033 Three words with din_valid held continuously -> third waits while din_ready=0; 24 contiguous valid bits, in order, none repeated.
